// File: rtl/hcx_pkg.sv
// Shared encodings for the HCx stack CPU: opcode nibbles, jump conditions,
// sequencer states and ALU function select.
package hcx_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } alu_sel_e;

  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_LDR = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_LSI = 4'hC;

  localparam logic [2:0] JC_JP   = 3'b000;
  localparam logic [2:0] JC_JC   = 3'b010;
  localparam logic [2:0] JC_JNC  = 3'b011;
  localparam logic [2:0] JC_JZ   = 3'b100;
  localparam logic [2:0] JC_JNZ  = 3'b101;
  localparam logic [2:0] JC_HALT = 3'b110;

  // Store-class opcodes 0x2..0x7 pick the ALU function from ir[6:4].
  function automatic alu_sel_e alu_sel_of(input logic [2:0] fn);
    case (fn)
      3'd2:    return ALU_ADD;
      3'd3:    return ALU_SUB;
      3'd4:    return ALU_AND;
      3'd5:    return ALU_OR;
      3'd6:    return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/hcx_if.sv
// Instruction and data memory req/ack ports of the HCx core.
interface hcx_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 16,
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_rdata;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata
  );

  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_rdata,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/hcx_alu.sv
// Combinational ALU; SUB is a + ~b + 1 so carry_out=1 means no borrow.
module hcx_alu
  import hcx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_e          sel,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum       = '0;
    result    = a;
    carry_out = 1'b0;
    case (sel)
      ALU_ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      ALU_SUB: begin
        sum       = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = a;
    endcase
  end
endmodule

// File: rtl/hcx_core.sv
// HCx stack CPU: FETCH/EXEC/HALT sequencer around a push-down stack and ALU,
// with req/ack instruction and data memory ports tolerating wait states.
module hcx_core
  import hcx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 3,
  parameter int PC_W        = 16,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              nReset,
  hcx_if.master             bus,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] stk_a,
  output logic [DATA_W-1:0] stk_b,
  output logic [DATA_W-1:0] stk_c,
  output logic [2:0]        flags_out,
  output logic              halted
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  state_e                                state, state_nx;
  logic [PC_W-1:0]                       pc;
  logic [7:0]                            ir;
  logic [STACK_DEPTH-1:0][DATA_W-1:0]    stk;
  logic [DEPTH_W-1:0]                    depth;
  logic                                  f_ovf, f_carry, f_zero;

  logic [3:0]          op, imm;
  logic                is_store, is_load, is_ldi, is_lsi, is_jmp, is_halt, mem_op, do_push;
  logic                jmp_take, commit, stk_full;
  logic [2*DATA_W-1:0] ba;
  logic [DATA_W-1:0]   alu_res, st_data, push_data;
  logic                alu_cy;
  alu_sel_e            alu_sel;

  // decode
  assign op       = ir[7:4];
  assign imm      = ir[3:0];
  assign is_store = ~ir[7];
  assign is_load  = (op == OP_LD) || (op == OP_LDR);
  assign is_ldi   = (op == OP_LDI);
  assign is_lsi   = (op == OP_LSI);
  assign is_jmp   = (ir[7:5] == 3'b111);
  assign is_halt  = is_jmp && (ir[2:0] == JC_HALT);
  assign mem_op   = is_store || is_load;
  assign do_push  = is_load || is_ldi;
  assign ba       = {stk[1], stk[0]};
  assign stk_full = (depth == DEPTH_W'(STACK_DEPTH));
  assign alu_sel  = alu_sel_of(ir[6:4]);

  hcx_alu #(.DATA_W(DATA_W)) u_alu (
    .a         (stk[0]),
    .b         (stk[1]),
    .sel       (alu_sel),
    .result    (alu_res),
    .carry_out (alu_cy)
  );

  assign st_data   = (ir[6:5] == 2'b00) ? stk[2] : alu_res;
  assign push_data = is_load ? bus.dmem_rdata : {stk[0][DATA_W-1:4], imm};

  always_comb begin
    jmp_take = 1'b0;
    case (ir[2:0])
      JC_JP:   jmp_take = 1'b1;
      JC_JC:   jmp_take = f_carry;
      JC_JNC:  jmp_take = ~f_carry;
      JC_JZ:   jmp_take = f_zero;
      JC_JNZ:  jmp_take = ~f_zero;
      default: jmp_take = 1'b0;
    endcase
  end

  // sequencer: state register
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) state <= ST_FETCH;
    else         state <= state_nx;

  // sequencer: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH: if (bus.imem_ack) state_nx = ST_EXEC;
      ST_EXEC:  if (commit)       state_nx = is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nx = ST_HALT;
      default:  state_nx = ST_FETCH;
    endcase
  end

  // sequencer: outputs; the fetch request is gated by reset so it drops the
  // moment reset asserts even though reset parks the sequencer in FETCH
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    commit       = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_FETCH: bus.imem_req = nReset;
      ST_EXEC: begin
        bus.dmem_req = mem_op;
        bus.dmem_we  = mem_op && is_store;
        commit       = !mem_op || bus.dmem_ack;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = (ir[6:4] == 3'b000) ? ba[ADDR_W-1:0] : ADDR_W'(imm);
  assign bus.dmem_wdata = st_data;

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (state == ST_FETCH && bus.imem_ack) ir <= bus.imem_rdata;
      if (commit) pc <= (is_jmp && jmp_take) ? ba[PC_W-1:0] : pc + PC_W'(1);
    end

  // entry 0 is the top; a push shifts everything down and drops the deepest
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      stk   <= '0;
      depth <= '0;
    end else if (commit) begin
      if (do_push) begin
        for (int i = STACK_DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
        stk[0] <= push_data;
        if (!stk_full) depth <= depth + DEPTH_W'(1);
      end else if (is_lsi) begin
        stk[0] <= {stk[0][DATA_W-5:0], imm};
      end
    end

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      f_ovf   <= 1'b0;
      f_carry <= 1'b0;
      f_zero  <= 1'b0;
    end else if (commit) begin
      if (is_store) begin
        f_zero <= (st_data == '0);
        if (op == OP_ADD || op == OP_SUB) f_carry <= alu_cy;
      end
      if (do_push && stk_full) f_ovf <= 1'b1;
    end

  assign pc_out    = pc;
  assign stk_a     = stk[0];
  assign stk_b     = stk[1];
  assign stk_c     = stk[2];
  assign flags_out = {f_ovf, f_carry, f_zero};

endmodule

// File: tb/tb_hcx_core.sv
// Bench for hcx_core: bench-side memories with wait states, an instruction-level
// reference model feeding expectation queues, and a monitor checking commits.
module tb_hcx_core;
  localparam int DATA_W      = 8;
  localparam int STACK_DEPTH = 3;
  localparam int PC_W        = 16;
  localparam int ADDR_W      = 16;
  localparam int DM = (1 << DATA_W) - 1;
  localparam int PM = (1 << PC_W) - 1;
  localparam int AM = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic [PC_W-1:0]   pc_out;
  logic [DATA_W-1:0] stk_a, stk_b, stk_c;
  logic [2:0]        flags_out;
  logic              halted;

  hcx_if #(.DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W)) bus ();

  hcx_core #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .nReset(nReset), .bus(bus),
    .pc_out(pc_out), .stk_a(stk_a), .stk_b(stk_b), .stk_c(stk_c),
    .flags_out(flags_out), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { int pc; int a; int b; int c; int flags; int halted; } arch_t;
  typedef struct { int we; int addr; int wdata; } dtx_t;
  arch_t exp_q[$];
  dtx_t  dexp_q[$];

  int total = 0;
  int bad = 0;

  logic [7:0]        imem [0:65535];
  logic [DATA_W-1:0] dmem [0:65535];
  logic [DATA_W-1:0] rmem [0:65535];

  // reference machine state
  int s [STACK_DEPTH];
  int depth, pc, iss_cnt;
  bit cf, zf, of, hlt;

  int imax = 0, dmax = 0, dfix = -1, fetch_limit = 1 << 30;
  bit chk2 = 0;
  int last_wa = -1, last_wd = -1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void iss_reset();
    for (int i = 0; i < STACK_DEPTH; i++) s[i] = 0;
    depth = 0; pc = 0; iss_cnt = 0;
    cf = 0; zf = 0; of = 0; hlt = 0;
  endfunction

  function automatic void iss_push(input int v);
    if (depth == STACK_DEPTH) of = 1;
    else depth++;
    for (int i = STACK_DEPTH - 1; i > 0; i--) s[i] = s[i-1];
    s[0] = v & DM;
  endfunction

  // one instruction executed at architectural level
  function automatic void iss_step(input int ir);
    int op, lo, a, b, c, ba, addr, v, sum, npc;
    bit take;
    arch_t e;
    dtx_t d;
    op = ir >> 4; lo = ir & 15;
    a = s[0]; b = s[1]; c = s[2];
    ba = (b << DATA_W) | a;
    addr = (((ir >> 4) & 7) == 0) ? (ba & AM) : lo;
    npc = (pc + 1) & PM;
    take = 0;
    if (op < 8) begin
      case (op)
        0, 1: v = c;
        2: begin sum = a + b; v = sum & DM; cf = (sum > DM); end
        3: begin sum = a + (DM - b) + 1; v = sum & DM; cf = (sum > DM); end
        4: v = a & b;
        5: v = a | b;
        6: v = a ^ b;
        default: v = a;
      endcase
      zf = (v == 0);
      rmem[addr] = v[DATA_W-1:0];
      d.we = 1; d.addr = addr; d.wdata = v;
      dexp_q.push_back(d);
    end else if (op == 8 || op == 9) begin
      v = int'(rmem[addr]);
      d.we = 0; d.addr = addr; d.wdata = 0;
      dexp_q.push_back(d);
      iss_push(v);
    end else if (op == 10) begin
      iss_push((a & (DM & ~15)) | lo);
    end else if (op == 12) begin
      s[0] = ((a << 4) | lo) & DM;
    end else if (op >= 14) begin
      case (lo & 7)
        0: take = 1;
        2: take = cf;
        3: take = !cf;
        4: take = zf;
        5: take = !zf;
        6: hlt = 1;
        default: take = 0;
      endcase
      if (take) npc = ba & PM;
    end
    pc = npc;
    iss_cnt++;
    e.pc = pc; e.a = s[0]; e.b = s[1]; e.c = s[2];
    e.flags = (int'(of) << 2) | (int'(cf) << 1) | int'(zf);
    e.halted = int'(hlt);
    exp_q.push_back(e);
  endfunction

  // instruction memory responder
  initial begin : imem_resp
    int w, b;
    bit busy;
    busy = 0; w = 0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      if (!nReset || !bus.imem_req || iss_cnt >= fetch_limit) busy = 0;
      else begin
        if (!busy) begin busy = 1; w = $urandom_range(0, imax); end
        if (w == 0) begin
          busy = 0;
          check("fetch_addr", 32'(bus.imem_addr), 32'(pc));
          b = int'(imem[bus.imem_addr]);
          bus.imem_rdata = b[7:0];
          bus.imem_ack = 1'b1;
          iss_step(b);
        end else w--;
      end
    end
  end

  // data memory responder
  initial begin : dmem_resp
    int w;
    bit busy;
    busy = 0; w = 0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      if (!nReset || !bus.dmem_req) busy = 0;
      else begin
        if (!busy) begin busy = 1; w = (dfix >= 0) ? dfix : $urandom_range(0, dmax); end
        if (w == 0) begin
          busy = 0;
          bus.dmem_ack = 1'b1;
          if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            last_wa = int'(bus.dmem_addr);
            last_wd = int'(bus.dmem_wdata);
          end else bus.dmem_rdata = dmem[bus.dmem_addr];
        end else w--;
      end
    end
  end

  // monitor: data transactions and instruction commits against the queues
  initial begin : mon
    bit prev_req, prev_halt, in_tx;
    int cyc, last_c, txc;
    logic [ADDR_W-1:0] ha;
    logic              hwe;
    logic [DATA_W-1:0] hwd, hsa;
    arch_t e;
    dtx_t d;
    prev_req = 1; prev_halt = 0; in_tx = 0; cyc = 0; last_c = -1; txc = 0;
    ha = '0; hwe = 1'b0; hwd = '0; hsa = '0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (!nReset) begin
        prev_req = 1; prev_halt = 0; in_tx = 0; last_c = -1;
        continue;
      end
      if (bus.dmem_req) begin
        if (!in_tx) begin
          in_tx = 1; txc = 0;
          ha = bus.dmem_addr; hwe = bus.dmem_we; hwd = bus.dmem_wdata; hsa = stk_a;
        end else begin
          check("dmem_addr_hold", 32'(bus.dmem_addr), 32'(ha));
          check("dmem_we_hold", 32'(bus.dmem_we), 32'(hwe));
          check("dmem_wdata_hold", 32'(bus.dmem_wdata), 32'(hwd));
          check("stk_hold_wait", 32'(stk_a), 32'(hsa));
        end
        txc++;
        if (bus.dmem_ack) begin
          in_tx = 0;
          if (dexp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL dmem_unexpected: got addr %0h expected no access", bus.dmem_addr);
          end else begin
            d = dexp_q.pop_front();
            check("dmem_we", 32'(bus.dmem_we), 32'(d.we));
            check("dmem_addr", 32'(bus.dmem_addr), 32'(d.addr));
            if (d.we != 0) check("dmem_wdata", 32'(bus.dmem_wdata), 32'(d.wdata));
            if (dfix >= 0) check("dmem_req_cycles", 32'(txc), 32'(dfix + 1));
          end
        end
      end
      if ((bus.imem_req && !prev_req) || (halted && !prev_halt)) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL commit_unexpected: got pc %0h expected no commit", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("pc", 32'(pc_out), 32'(e.pc));
          check("stk_a", 32'(stk_a), 32'(e.a));
          check("stk_b", 32'(stk_b), 32'(e.b));
          check("stk_c", 32'(stk_c), 32'(e.c));
          check("flags", 32'(flags_out), 32'(e.flags));
          check("halted", 32'(halted), 32'(e.halted));
          if (chk2 && last_c >= 0) check("clk_per_instr", 32'(cyc - last_c), 32'd2);
          last_c = cyc;
        end
      end
      prev_req = bus.imem_req;
      prev_halt = halted;
    end
  end

  task automatic init_mem(input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) begin
      b = 8'hE6;
      if (rnd) begin
        b = 8'($urandom_range(0, 255));
        if (b[7:5] == 3'b111 && b[2:0] == 3'b110) b = 8'hB0;
      end
      imem[i] = b;
      dmem[i] = DATA_W'($urandom);
      rmem[i] = dmem[i];
    end
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    exp_q.delete();
    dexp_q.delete();
    iss_reset();
    last_wa = -1; last_wd = -1;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dexp_q.size() != 0 || (!hlt && iss_cnt < fetch_limit)) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    #2;
    total++;
    if (n >= maxc) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int viol;
    iss_reset();

    // reset abandons a stalled fetch
    init_mem(0);
    imem[0] = 8'hA5; imem[1] = 8'hA3;
    fetch_limit = 2;
    do_reset();
    wait_drain(100);
    check("t1_req_stalled", 32'(bus.imem_req), 32'd1);
    @(posedge clk); #2;
    nReset = 1'b0;
    #1;
    check("t1_imem_req", 32'(bus.imem_req), 32'd0);
    check("t1_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("t1_pc", 32'(pc_out), 32'd0);
    check("t1_flags", 32'(flags_out), 32'd0);
    check("t1_stk", 32'({stk_a, stk_b, stk_c}), 32'd0);
    check("t1_halted", 32'(halted), 32'd0);
    fetch_limit = 1 << 30;

    // zero-wait push4, push1, ADD r8
    init_mem(0);
    imem[0] = 8'hA4; imem[1] = 8'hA1; imem[2] = 8'h28;
    chk2 = 1;
    do_reset();
    wait_drain(100);
    chk2 = 0;
    check("t2_waddr", 32'(last_wa), 32'h8);
    check("t2_wdata", 32'(last_wd), 32'h5);
    check("t2_flags", 32'(flags_out), 32'b000);
    check("t2_pc", 32'(pc_out), 32'h4);

    // LD r2 with three wait states
    init_mem(0);
    imem[0] = 8'hA5; imem[1] = 8'hA0; imem[2] = 8'h92;
    dmem[2] = 8'h3C; rmem[2] = 8'h3C;
    dfix = 3;
    do_reset();
    wait_drain(100);
    dfix = -1;
    check("t3_stk_a", 32'(stk_a), 32'h3C);
    check("t3_stk_c", 32'(stk_c), 32'h05);

    // SUB 1-2 then JNC to {B,A}
    init_mem(0);
    imem[0] = 8'hA2; imem[1] = 8'hA1; imem[2] = 8'h3F; imem[3] = 8'hE3;
    do_reset();
    wait_drain(100);
    check("t4_wdata", 32'(last_wd), 32'hFF);
    check("t4_waddr", 32'(last_wa), 32'hF);
    check("t4_flags", 32'(flags_out), 32'b000);
    check("t4_pc", 32'(pc_out), 32'h0202);

    // overflow on a fourth push, sticky afterwards
    init_mem(0);
    imem[0] = 8'hA1; imem[1] = 8'hA2; imem[2] = 8'hA3; imem[3] = 8'hA4;
    imem[4] = 8'h2F; imem[5] = 8'hC5;
    do_reset();
    wait_drain(100);
    check("t5_flags", 32'(flags_out), 32'b100);
    check("t5_stk", 32'({stk_a, stk_b, stk_c}), 32'h450302);

    // HALT at 0x0010
    init_mem(0);
    for (int i = 0; i < 16; i++) imem[i] = 8'hD0;
    do_reset();
    wait_drain(200);
    check("t6_halted", 32'(halted), 32'd1);
    check("t6_pc", 32'(pc_out), 32'h0011);
    viol = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.imem_req || bus.dmem_req) viol++;
    end
    check("t6_no_req", 32'(viol), 32'd0);

    // random programs with random wait states
    for (int r = 0; r < 4; r++) begin
      init_mem(1);
      imax = r; dmax = 2 * r;
      fetch_limit = 300;
      do_reset();
      wait_drain(20000);
    end
    fetch_limit = 1 << 30;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
